// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants, ID/EX bundle and FSM encoding for id_stage_pipe.
// Shift decoding is enabled by defining ID_SHIFT_EN.
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [7:0] ALU_NOP = 8'b00000000;
  localparam logic [7:0] ALU_AND = 8'b00100100;
  localparam logic [7:0] ALU_OR  = 8'b00100101;
  localparam logic [7:0] ALU_XOR = 8'b00100110;
  localparam logic [7:0] ALU_NOR = 8'b00100111;
  localparam logic [7:0] ALU_SLL = 8'b01111100;
  localparam logic [7:0] ALU_SRL = 8'b00000010;
  localparam logic [7:0] ALU_SRA = 8'b00000011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  typedef enum logic {ST_RUN, ST_STALL} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        inv;
  } id_ex_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic [4:0]  wd;
    logic        re1;
    logic        re2;
    logic [31:0] imm;
    logic        inv;
  } dec_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  localparam dec_t DEC_NOP = '{
    aluop: ALU_NOP, alusel: SEL_NOP, wreg: 1'b0, wd: 5'd0,
    re1: 1'b0, re2: 1'b0, imm: 32'h0, inv: 1'b0};

  localparam dec_t DEC_INVALID = '{
    aluop: ALU_NOP, alusel: SEL_NOP, wreg: 1'b0, wd: 5'd0,
    re1: 1'b0, re2: 1'b0, imm: 32'h0, inv: 1'b1};

  function automatic dec_t mk_dec(
    input logic [7:0]  aluop,
    input logic [2:0]  alusel,
    input logic [4:0]  wd,
    input logic        re1,
    input logic        re2,
    input logic [31:0] imm
  );
    mk_dec = '{aluop: aluop, alusel: alusel, wreg: 1'b1, wd: wd,
               re1: re1, re2: re2, imm: imm, inv: 1'b0};
  endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// Operand select for one read port: immediate, $0, youngest forward, regfile.
module id_fwd_mux #(
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]            addr,
  input  logic                  re,
  input  logic [31:0]           rdata,
  input  logic [31:0]           imm,
  input  logic [NUM_FWD-1:0]    fwd_wreg,
  input  logic [NUM_FWD*5-1:0]  fwd_wd,
  input  logic [NUM_FWD*32-1:0] fwd_wdata,
  output logic [31:0]           operand
);

  always_comb begin
    operand = rdata;
    // walk oldest to youngest so the lowest index wins
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wreg[k] && fwd_wd[k*5 +: 5] == addr)
        operand = fwd_wdata[k*32 +: 32];
    end
    if (addr == 5'd0) operand = 32'h0;
    if (!re) operand = imm;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS32 decode stage with forwarding, load-use stall FSM and ID/EX register.
// Define ID_SHIFT_EN to decode SLL/SRL/SRA/SLLV/SRLV/SRAV.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           reg1_data_i,
  input  logic [31:0]           reg2_data_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [4:0]            reg1_addr_o,
  output logic [4:0]            reg2_addr_o,
  input  logic [NUM_FWD-1:0]    fwd_wreg_i,
  input  logic [NUM_FWD*5-1:0]  fwd_wd_i,
  input  logic [NUM_FWD*32-1:0] fwd_wdata_i,
  input  logic                  ex_load_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic                  stall_req_o,
  output logic                  ex_valid_o,
  output logic [31:0]           ex_pc_o,
  output logic [7:0]            aluop_o,
  output logic [2:0]            alusel_o,
  output logic [31:0]           reg1_o,
  output logic [31:0]           reg2_o,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic                  inst_invalid_o
);

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] zimm, limm;
  dec_t        dec;
  logic [31:0] op1, op2;
  logic        hazard;
  state_e      state, state_n;
  logic [2:0]  cnt, cnt_n;
  id_ex_t      ex, ex_n, issue;

  assign op   = inst_i[31:26];
  assign rs   = inst_i[25:21];
  assign rt   = inst_i[20:16];
  assign rd   = inst_i[15:11];
  assign fn   = inst_i[5:0];
  assign zimm = {16'h0, inst_i[15:0]};
  assign limm = {inst_i[15:0], 16'h0};

`ifdef ID_SHIFT_EN
  logic [31:0] sa_imm;
  assign sa_imm = {27'h0, inst_i[10:6]};
`else
  logic unused_sa;
  assign unused_sa = ^inst_i[10:6];
`endif

  always_comb begin
    dec = DEC_INVALID;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_AND:  dec = mk_dec(ALU_AND, SEL_LOGIC, rd, 1'b1, 1'b1, '0);
          FN_OR:   dec = mk_dec(ALU_OR,  SEL_LOGIC, rd, 1'b1, 1'b1, '0);
          FN_XOR:  dec = mk_dec(ALU_XOR, SEL_LOGIC, rd, 1'b1, 1'b1, '0);
          FN_NOR:  dec = mk_dec(ALU_NOR, SEL_LOGIC, rd, 1'b1, 1'b1, '0);
          FN_SYNC: dec = DEC_NOP;
`ifdef ID_SHIFT_EN
          FN_SLL:  dec = mk_dec(ALU_SLL, SEL_SHIFT, rd, 1'b0, 1'b1, sa_imm);
          FN_SRL:  dec = mk_dec(ALU_SRL, SEL_SHIFT, rd, 1'b0, 1'b1, sa_imm);
          FN_SRA:  dec = mk_dec(ALU_SRA, SEL_SHIFT, rd, 1'b0, 1'b1, sa_imm);
          FN_SLLV: dec = mk_dec(ALU_SLL, SEL_SHIFT, rd, 1'b1, 1'b1, '0);
          FN_SRLV: dec = mk_dec(ALU_SRL, SEL_SHIFT, rd, 1'b1, 1'b1, '0);
          FN_SRAV: dec = mk_dec(ALU_SRA, SEL_SHIFT, rd, 1'b1, 1'b1, '0);
`endif
          default: dec = DEC_INVALID;
        endcase
      end
      OP_ANDI: dec = mk_dec(ALU_AND, SEL_LOGIC, rt, 1'b1, 1'b0, zimm);
      OP_ORI:  dec = mk_dec(ALU_OR,  SEL_LOGIC, rt, 1'b1, 1'b0, zimm);
      OP_XORI: dec = mk_dec(ALU_XOR, SEL_LOGIC, rt, 1'b1, 1'b0, zimm);
      OP_LUI:  dec = mk_dec(ALU_OR,  SEL_LOGIC, rt, 1'b1, 1'b0, limm);
      OP_PREF: dec = DEC_NOP;
      default: dec = DEC_INVALID;
    endcase
  end

  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;
  assign reg1_read_o = dec.re1;
  assign reg2_read_o = dec.re2;

  id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd1 (
    .addr(rs), .re(dec.re1), .rdata(reg1_data_i), .imm(dec.imm),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i),
    .fwd_wdata(fwd_wdata_i), .operand(op1)
  );

  id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd2 (
    .addr(rt), .re(dec.re2), .rdata(reg2_data_i), .imm(dec.imm),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i),
    .fwd_wdata(fwd_wdata_i), .operand(op2)
  );

  // slot 0 is the load still in EX; its data is not ready yet
  assign hazard = state == ST_RUN && valid_i && ex_load_i
               && fwd_wreg_i[0] && fwd_wd_i[4:0] != 5'd0
               && ((dec.re1 && fwd_wd_i[4:0] == rs)
                || (dec.re2 && fwd_wd_i[4:0] == rt));

  assign issue = '{valid: 1'b1, pc: pc_i, aluop: dec.aluop,
                   alusel: dec.alusel, reg1: op1, reg2: op2,
                   wd: dec.wd, wreg: dec.wreg, inv: dec.inv};

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall_req_o = 1'b0;
    ex_n        = valid_i ? issue : ID_EX_BUBBLE;
    unique case (state)
      ST_RUN: begin
        stall_req_o = hazard;
        if (hazard) begin
          state_n = ST_STALL;
          cnt_n   = 3'(LOAD_LAT - 1);
          ex_n    = ID_EX_BUBBLE;
        end
      end
      ST_STALL: begin
        stall_req_o = cnt != 3'd0;
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
          ex_n  = ID_EX_BUBBLE;
        end else begin
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex    <= ID_EX_BUBBLE;
      state <= ST_RUN;
      cnt   <= 3'd0;
    end else if (flush_i) begin
      ex    <= ID_EX_BUBBLE;
      state <= ST_RUN;
      cnt   <= 3'd0;
    end else if (!hold_i) begin
      ex    <= ex_n;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign ex_valid_o     = ex.valid;
  assign ex_pc_o        = ex.pc;
  assign aluop_o        = ex.aluop;
  assign alusel_o       = ex.alusel;
  assign reg1_o         = ex.reg1;
  assign reg2_o         = ex.reg2;
  assign wd_o           = ex.wd;
  assign wreg_o         = ex.wreg;
  assign inst_invalid_o = ex.inv;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe (NUM_FWD=3, LOAD_LAT=2).
// Directed vectors; expected ID/EX contents queued per clock.
module tb_id_stage_pipe;

  localparam int NF = 3;
  localparam int LL = 2;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        w;
    logic        inv;
  } exp_t;

  localparam exp_t BUB = '0;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           valid_i = 1'b0;
  logic [31:0]    pc_i = '0;
  logic [31:0]    inst_i = '0;
  logic [31:0]    reg1_data_i = '0;
  logic [31:0]    reg2_data_i = '0;
  logic           reg1_read_o, reg2_read_o;
  logic [4:0]     reg1_addr_o, reg2_addr_o;
  logic [NF-1:0]    fwd_wreg_i = '0;
  logic [NF*5-1:0]  fwd_wd_i = '0;
  logic [NF*32-1:0] fwd_wdata_i = '0;
  logic           ex_load_i = 1'b0;
  logic           hold_i = 1'b0;
  logic           flush_i = 1'b0;
  logic           stall_req_o;
  logic           ex_valid_o;
  logic [31:0]    ex_pc_o;
  logic [7:0]     aluop_o;
  logic [2:0]     alusel_o;
  logic [31:0]    reg1_o, reg2_o;
  logic [4:0]     wd_o;
  logic           wreg_o;
  logic           inst_invalid_o;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t me, mg;

  id_stage_pipe #(.NUM_FWD(NF), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
    .inst_i(inst_i), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .reg1_read_o(reg1_read_o),
    .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o),
    .reg2_addr_o(reg2_addr_o), .fwd_wreg_i(fwd_wreg_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_load_i(ex_load_i), .hold_i(hold_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .inst_invalid_o(inst_invalid_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] pc, input logic [7:0] op,
    input logic [2:0] sel, input logic [31:0] r1,
    input logic [31:0] r2, input logic [4:0] wd,
    input logic w, input logic inv
  );
    mk = '{1'b1, pc, op, sel, r1, r2, wd, w, inv};
  endfunction

  function automatic exp_t got();
    got = '{ex_valid_o, ex_pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
            wd_o, wreg_o, inst_invalid_o};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst && q.size() > 0) begin
      me = q.pop_front();
      mg = got();
      checks++;
      if (mg !== me) begin
        errors++;
        $display("FAIL sb pc=%h got=%h exp=%h", me.pc, mg, me);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] g,
                     input logic [31:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, g, x);
    end
  endtask

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic v, input logic [31:0] pc,
                     input logic [31:0] inst, input logic [31:0] r1,
                     input logic [31:0] r2);
    valid_i = v; pc_i = pc; inst_i = inst;
    reg1_data_i = r1; reg2_data_i = r2;
  endtask

  task automatic fwd(input int k, input logic w, input logic [4:0] d,
                     input logic [31:0] data);
    fwd_wreg_i[k] = w;
    fwd_wd_i[k*5 +: 5] = d;
    fwd_wdata_i[k*32 +: 32] = data;
  endtask

  task automatic clr_fwd();
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
    ex_load_i = 1'b0;
  endtask

  task automatic chk_bubble(input string n);
    chk({n, "_valid"}, {31'h0, ex_valid_o}, 32'h0);
    chk({n, "_pc"}, ex_pc_o, 32'h0);
    chk({n, "_ops"}, reg1_o | reg2_o, 32'h0);
    chk({n, "_ctl"}, {13'h0, aluop_o, alusel_o, wd_o, wreg_o,
        inst_invalid_o}, 32'h0);
    chk({n, "_stall"}, {31'h0, stall_req_o}, 32'h0);
  endtask

  localparam logic [31:0] I_ORI  = 32'h34221234;
  localparam logic [31:0] I_ORI1 = 32'h34220001;
  localparam logic [31:0] I_OR   = 32'h00221825;
  localparam logic [31:0] I_OR0  = 32'h00021825;
  localparam logic [31:0] I_AND  = 32'h00223024;
  localparam logic [31:0] I_XORI = 32'h3827FFFF;
  localparam logic [31:0] I_LUI  = 32'h3C05ABCD;
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  localparam logic [31:0] I_SYNC = 32'h0000000F;
  localparam logic [31:0] I_SLL  = 32'h000520C0;

  initial begin
    #3;
    chk_bubble("reset0");
    @(posedge clk);
    #2;
    rst = 1'b1;

    drv(1, 32'h0, I_ORI, 32'hF0, 32'h0);
    #1;
    chk("ori_r1addr", {27'h0, reg1_addr_o}, 32'd1);
    chk("ori_r2addr", {27'h0, reg2_addr_o}, 32'd2);
    chk("ori_re", {30'h0, reg1_read_o, reg2_read_o}, 32'b10);
    step(mk(32'h0, 8'h25, 3'b001, 32'hF0, 32'h1234, 5'd2, 1, 0));

    drv(1, 32'h4, I_OR, 32'h0, 32'h9999);
    fwd(0, 1, 5'd1, 32'hAAAA);
    fwd(1, 1, 5'd1, 32'h5555);
    fwd(2, 1, 5'd2, 32'h2222);
    #1;
    chk("or_re", {30'h0, reg1_read_o, reg2_read_o}, 32'b11);
    step(mk(32'h4, 8'h25, 3'b001, 32'hAAAA, 32'h2222, 5'd3, 1, 0));
    drv(1, 32'h8, I_OR, 32'h0, 32'h9999);
    fwd(0, 0, 5'd1, 32'hAAAA);
    step(mk(32'h8, 8'h25, 3'b001, 32'h5555, 32'h2222, 5'd3, 1, 0));

    drv(1, 32'hC, I_OR0, 32'h4444, 32'h9999);
    fwd(0, 1, 5'd0, 32'h1111);
    fwd(1, 1, 5'd0, 32'h2222);
    fwd(2, 1, 5'd0, 32'h3333);
    step(mk(32'hC, 8'h25, 3'b001, 32'h0, 32'h9999, 5'd3, 1, 0));
    clr_fwd();

    drv(1, 32'h10, I_AND, 32'h0F0F, 32'h00FF);
    step(mk(32'h10, 8'h24, 3'b001, 32'h0F0F, 32'h00FF, 5'd6, 1, 0));
    drv(1, 32'h14, I_XORI, 32'h1, 32'h0);
    step(mk(32'h14, 8'h26, 3'b001, 32'h1, 32'hFFFF, 5'd7, 1, 0));
    drv(1, 32'h18, I_LUI, 32'h1234, 32'h0);
    step(mk(32'h18, 8'h25, 3'b001, 32'h0, 32'hABCD0000, 5'd5, 1, 0));
    drv(1, 32'h1C, I_BAD, 32'h0, 32'h0);
    step(mk(32'h1C, 8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 0, 1));
    drv(1, 32'h20, I_SYNC, 32'h0, 32'h0);
    step(mk(32'h20, 8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0));
    drv(1, 32'h24, I_SLL, 32'h0, 32'h55);
`ifdef ID_SHIFT_EN
    step(mk(32'h24, 8'h7C, 3'b010, 32'h3, 32'h55, 5'd4, 1, 0));
`else
    step(mk(32'h24, 8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 0, 1));
`endif
    drv(0, 32'h28, I_ORI, 32'h1, 32'h0);
    step(BUB);

    // load-use, two bubbles
    drv(1, 32'h100, I_ORI1, 32'h0, 32'h0);
    ex_load_i = 1'b1;
    fwd(0, 1, 5'd1, 32'hDEAD);
    #1;
    chk("lu_stall_a", {31'h0, stall_req_o}, 32'd1);
    step(BUB);
    clr_fwd();
    fwd(1, 1, 5'd1, 32'hDEAD);
    #1;
    chk("lu_stall_b", {31'h0, stall_req_o}, 32'd1);
    step(BUB);
    clr_fwd();
    fwd(2, 1, 5'd1, 32'h77);
    #1;
    chk("lu_stall_c", {31'h0, stall_req_o}, 32'd0);
    step(mk(32'h100, 8'h25, 3'b001, 32'h77, 32'h1, 5'd2, 1, 0));
    clr_fwd();
    drv(0, 32'h104, I_ORI1, 32'h0, 32'h0);
    step(BUB);

    // load-use with two held cycles inside STALL
    drv(1, 32'h200, I_ORI1, 32'h0, 32'h0);
    ex_load_i = 1'b1;
    fwd(0, 1, 5'd1, 32'hDEAD);
    step(BUB);
    clr_fwd();
    hold_i = 1'b1;
    step(BUB);
    #1;
    chk("hold_stall", {31'h0, stall_req_o}, 32'd1);
    step(BUB);
    hold_i = 1'b0;
    step(BUB);
    fwd(2, 1, 5'd1, 32'h88);
    step(mk(32'h200, 8'h25, 3'b001, 32'h88, 32'h1, 5'd2, 1, 0));
    clr_fwd();

    // flush beats hold, then flush in STALL
    drv(1, 32'h308, I_ORI1, 32'h5, 32'h0);
    step(mk(32'h308, 8'h25, 3'b001, 32'h5, 32'h1, 5'd2, 1, 0));
    drv(1, 32'h30C, I_ORI1, 32'h5, 32'h0);
    flush_i = 1'b1; hold_i = 1'b1;
    step(BUB);
    flush_i = 1'b0; hold_i = 1'b0;
    drv(1, 32'h300, I_ORI1, 32'h0, 32'h0);
    ex_load_i = 1'b1;
    fwd(0, 1, 5'd1, 32'hDEAD);
    step(BUB);
    clr_fwd();
    flush_i = 1'b1;
    step(BUB);
    flush_i = 1'b0;
    drv(1, 32'h304, I_ORI1, 32'h6, 32'h0);
    #1;
    chk("flush_stall", {31'h0, stall_req_o}, 32'd0);
    step(mk(32'h304, 8'h25, 3'b001, 32'h6, 32'h1, 5'd2, 1, 0));

    // async reset in STALL
    drv(1, 32'h400, I_ORI1, 32'h0, 32'h0);
    ex_load_i = 1'b1;
    fwd(0, 1, 5'd1, 32'hDEAD);
    step(BUB);
    clr_fwd();
    chk("pre_rst_stall", {31'h0, stall_req_o}, 32'd1);
    #1 rst = 1'b0;
    #1 chk_bubble("rst_stall");
    @(negedge clk);
    rst = 1'b1;
    drv(1, 32'h500, I_ORI1, 32'h9, 32'h0);
    step(mk(32'h500, 8'h25, 3'b001, 32'h9, 32'h1, 5'd2, 1, 0));

    // async reset with a live instruction in ID/EX
    drv(0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    #1 chk_bubble("rst_live");
    @(negedge clk);
    rst = 1'b1;
    step(BUB);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the MIPS32 pipeline that also owns the ID/EX pipeline register. It decodes the instruction presented by IF/ID and selects operands through an N-source forwarding network, youngest source first. It detects load-use hazards and inserts a configurable number of bubbles through a small state machine. All EX-facing outputs are registered, with hold and flush control from the pipeline controller.

## Interface
- NUM_FWD, default 2: number of forwarding sources; index 0 is the youngest (EX). Must be ≥ LOAD_LAT+1.
- LOAD_LAT, default 1: bubbles inserted on a load-use hazard; legal range 1..7.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  pc_i/inst_i carry a real instruction.
- pc_i  in  32  instruction address.
- inst_i  in  32  instruction word.
- reg1_data_i, reg2_data_i  in  32  regfile read data.
- reg1_read_o, reg2_read_o  out  1  regfile read enables (comb).
- reg1_addr_o, reg2_addr_o  out  5  rs = inst[25:21], rt = inst[20:16] (comb).
- fwd_wreg_i  in  NUM_FWD  per-source write enable.
- fwd_wd_i  in  NUM_FWD*5  per-source destination; source k occupies [5k+4:5k].
- fwd_wdata_i  in  NUM_FWD*32  per-source result; source k occupies [32k+31:32k].
- ex_load_i  in  1  instruction in EX is a load; its slot-0 data is not yet valid.
- hold_i  in  1  downstream stall.
- flush_i  in  1  kill the ID/EX contents.
- stall_req_o  out  1  load-use stall request to IF/ID (comb).
- ex_valid_o  out  1  registered; ID/EX holds a real instruction.
- ex_pc_o  out  32  registered.
- aluop_o  out  8  registered.
- alusel_o  out  3  registered.
- reg1_o, reg2_o  out  32  registered operands.
- wd_o  out  5  registered destination.
- wreg_o  out  1  registered write enable.
- inst_invalid_o  out  1  registered; set for an unrecognised opcode.

## Operation
- Decoded classes:
  - Register ops: OR, AND, XOR, NOR (rd ← rs op rt).
  - Immediate ops: ORI, ANDI, XORI (rt ← rs op zext(imm16)); LUI (rt ← rs OR {imm16,16'h0}).
  - Shifts: SLL, SRL, SRA (rd ← rt shifted by sa; sa zero-extended into the operand-1 immediate). SLLV, SRLV, SRAV (rd ← rt shifted by rs).
  - No-ops: SYNC and PREF are valid no-ops.
- Unrecognised opcode: ex_valid_o=1, inst_invalid_o=1, wreg_o=0, aluop/alusel NOP.
- Operand select, per read port:
  - If the read enable is 0, the operand is the immediate.
  - Otherwise, if the address is 0, the operand is 32'h0.
  - Otherwise, the lowest-index source k with fwd_wreg_i[k]=1 and a matching fwd_wd_i supplies the operand.
  - If no source matches, reg*_data_i supplies it.
  - A source never forwards to $0.
- Hazard condition: state RUN, valid_i=1, ex_load_i=1, fwd_wreg_i[0]=1, fwd_wd_i[0]≠0, and fwd_wd_i[0] matches an enabled read address.
- FSM:
  - RUN → STALL when the hazard condition holds and hold_i=0. Load cnt=LOAD_LAT−1, register a bubble, stall_req_o=1.
  - STALL: stall_req_o=(cnt≠0), and a bubble is registered while cnt≠0. cnt decrements each non-held cycle.
  - STALL → RUN: at cnt=0 the instruction issues normally in that cycle (no hazard re-check).
- Register update priority: flush_i > hold_i > normal.
  - flush_i: registers bubble, FSM → RUN, cnt=0, stall_req_o=0.
  - hold_i: all registers and the FSM hold. stall_req_o keeps its value.
- Bubble: ex_valid_o=0, aluop 8'h00, alusel 3'b000, wreg 0, wd 0, reg1/reg2 0, pc 0, inst_invalid 0.
- valid_i=0 registers a bubble.

## Timing
- Reset: every registered output takes its bubble value, FSM=RUN, cnt=0, and stall_req_o=0. Reset takes effect immediately on rst falling, independent of clk.
- Decode-to-EX latency is 1 cycle.
- Combinational outputs: regfile address and enable outputs, and stall_req_o, are driven combinationally from inst_i and the FSM state.
- A load-use hazard costs exactly LOAD_LAT bubbles, plus any hold_i cycles.
- Dependent instruction issue: it issues in the cycle after the last bubble, taking its operand from forwarding slot LOAD_LAT.
- hold_i and flush_i together: flush wins.

## Configuration
- ID_SHIFT_EN defined: all six shift instructions decode as above.
- ID_SHIFT_EN undefined: the shift funct codes decode as invalid, and SLL with inst=0 still counts as invalid. SYNC is unaffected.

## Structure
- Shared package holds: opcode and funct constants, AluOp/AluSel encodings, the NOP and bubble constants, and the FSM state encoding.
- Sub-module id_fwd_mux: address, read enable, regfile data, immediate and flattened forwarding buses in; operand out. It is instantiated once per read port.

## Test plan
- Reset: assert rst=0 mid-STALL → all registered outputs at bubble values and stall_req_o=0 immediately; after release the first valid instruction issues.
- ORI $2,$1,0x1234 with reg1_data_i=0xF0 and no forwarding → next cycle aluop OR, reg1_o=0xF0, reg2_o=0x1234, wd_o=2, wreg_o=1.
- OR $3,$1,$2 with slot0 ($1, 0xAAAA) and slot1 ($1, 0x5555) both writing → reg1_o=0xAAAA. Repeat with both slots writing $0 for OR $3,$0,$2 → reg1_o=0.
- Load-use, LOAD_LAT=1: ex_load_i=1, slot0 writes $1, inst reads $1 → stall_req_o=1 for one cycle and ex_valid_o=0. The next cycle issues with slot1 data 0x77.
- LOAD_LAT=2 with hold_i asserted for 2 cycles during STALL → exactly 2 bubbles plus held cycles. flush_i during STALL → bubble, RUN, stall_req_o=0.
- SLL $4,$5,3 with ID_SHIFT_EN undefined → inst_invalid_o=1, wreg_o=0. With ID_SHIFT_EN defined → aluop SLL, reg1_o=3, wd_o=4.
